dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port synchronous data RAM between the pipeline MEM stage (CPU port) and an external DMA/debug port (program loader, memory inspection).
- CPU has priority by default. DMA is served in idle CPU cycles, or is forced in once its wait counter saturates. An optional locked burst lets DMA hold the RAM.
- `cpu_stall` feeds the pipeline stall logic, which freezes the PC, IF/ID, ID/EX and EX/MEM registers.

Parameters:
- RAM_SIZE_BIT, 8, word-address width of the RAM
- MAX_WAIT, 4, DMA wait cycles before a forced grant (1..15)
- BURST_MAX, 8, maximum beats per locked DMA burst (1..255)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- cpu_req  in  1  CPU access request (MEM-stage read or write)
- cpu_we  in  1  CPU write enable
- cpu_addr  in  RAM_SIZE_BIT  CPU word address
- cpu_wdata  in  32  CPU write data
- cpu_stall  out  1  CPU access not granted this cycle; hold request stable
- cpu_rdata  out  32  CPU read data
- cpu_rvalid  out  1  cpu_rdata valid (one cycle after granted read)
- dma_valid  in  1  DMA request valid
- dma_we  in  1  DMA write enable
- dma_lock  in  1  request/extend locked burst
- dma_addr  in  RAM_SIZE_BIT  DMA word address
- dma_wdata  in  32  DMA write data
- dma_ready  out  1  DMA beat accepted this cycle
- dma_rdata  out  32  DMA read data
- dma_rvalid  out  1  dma_rdata valid
- ram_en  out  1  RAM enable
- ram_we  out  1  RAM write enable
- ram_addr  out  RAM_SIZE_BIT  RAM address
- ram_din  out  32  RAM write data
- ram_dout  in  32  RAM read data, one-cycle latency
- stat_stall_cnt  out  16  CPU stall cycle count (optional feature)
- stat_dma_cnt  out  16  DMA beats accepted (optional feature)

Behaviour:
- Reset values:
  - All outputs 0.
  - State ST_CPU; wait_cnt=0, beat_cnt=0, rd_owner=NONE.
  - Reset mid-burst aborts the burst; no pending rvalid is emitted.
- Grant is combinational within the cycle; RAM signals are driven from the granted port the same cycle.
- ST_CPU:
  - cpu_req=1 and wait_cnt<MAX_WAIT: grant CPU.
  - cpu_req=0 and dma_valid=1: grant DMA, dma_ready=1.
  - cpu_req=1, dma_valid=1, wait_cnt==MAX_WAIT: grant DMA, cpu_stall=1.
  - Neither requests: ram_en=0.
- wait_cnt:
  - Increments each cycle dma_valid=1 and DMA is not granted; saturates at MAX_WAIT.
  - Clears on any DMA grant, or when dma_valid=0.
- Burst entry and ST_DMA_BURST:
  - A DMA grant with dma_lock=1 moves to ST_DMA_BURST; beat_cnt=1.
  - In ST_DMA_BURST the DMA always owns the RAM and cpu_stall=cpu_req.
  - A beat is accepted (dma_ready=1) only if dma_valid=1; beat_cnt increments per accepted beat.
- Burst exit to ST_CPU, at the end of the cycle, when any of:
  - dma_lock=0;
  - beat_cnt reaches BURST_MAX after an accepted beat;
  - dma_valid=0 for 2 consecutive cycles (idle timeout).
- Lock-out after burst: after burst exit, CPU is guaranteed the next cycle. DMA cannot re-lock until at least one cycle has passed in ST_CPU.
- Read return:
  - rd_owner registers the granted port of a read (ram_we=0).
  - Next cycle, the owner's rvalid=1 and its rdata=ram_dout; the other port's rdata holds its previous value.
  - Writes produce no rvalid.
- cpu_stall is never asserted when cpu_req=0.
- Stall contract: while stalled, the CPU holds addr/we/wdata; the arbiter does not latch them.
- Simultaneous write and read to the same address in consecutive cycles: the RAM returns the new data (write-first RAM). No extra forwarding.
- Address widths are passed unchanged; no wrap logic.

Optional Feature:
- DMEM_ARB_STATS_EN defined:
  - stat_stall_cnt increments each cycle cpu_stall=1.
  - stat_dma_cnt increments each cycle dma_ready=1.
  - Both saturate at 16'hFFFF and clear on reset.
- Undefined: both outputs tied to 0 and the counters are not synthesized.

Test Plan:
- CPU read only: cpu_req=1, we=0, addr=8'h10 with RAM[0x10]=32'hDEADBEEF -> next cycle cpu_rvalid=1, cpu_rdata=DEADBEEF; cpu_stall=0 throughout.
- DMA in idle slot: cpu_req=0, dma write addr=8'h20 data=32'h12345678, then CPU reads 0x20 -> dma_ready=1 same cycle; CPU read returns 12345678.
- Starvation with MAX_WAIT=4: cpu_req=1 continuously, dma_valid=1 from cycle 0 -> DMA granted at cycle 4; cpu_stall=1 only in cycle 4; wait_cnt returns to 0.
- Locked burst: dma_lock=1, 10 back-to-back beats, BURST_MAX=8, cpu_req=1 -> 8 beats accepted, cpu_stall=1 for 8 cycles. CPU is granted the next cycle; remaining DMA beats resume only after the lock-out cycle.
- Reset mid-burst: reset asserted at beat 3 of a read burst -> next cycle all outputs 0, dma_rvalid=0; state ST_CPU, and a CPU request is granted immediately after reset releases.
- Stats (DMEM_ARB_STATS_EN): rerun the starvation scenario for 20 cycles -> stat_stall_cnt=4, stat_dma_cnt=4.

Source files
------------

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - data RAM arbiter between CPU MEM stage and DMA/debug port (optional stats: DMEM_ARB_STATS_EN)
module dmem_arbiter #(
    parameter int RAM_SIZE_BIT = 8,
    parameter int MAX_WAIT     = 4,
    parameter int BURST_MAX    = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cpu_req,
    input  logic                    cpu_we,
    input  logic [RAM_SIZE_BIT-1:0] cpu_addr,
    input  logic [31:0]             cpu_wdata,
    output logic                    cpu_stall,
    output logic [31:0]             cpu_rdata,
    output logic                    cpu_rvalid,
    input  logic                    dma_valid,
    input  logic                    dma_we,
    input  logic                    dma_lock,
    input  logic [RAM_SIZE_BIT-1:0] dma_addr,
    input  logic [31:0]             dma_wdata,
    output logic                    dma_ready,
    output logic [31:0]             dma_rdata,
    output logic                    dma_rvalid,
    output logic                    ram_en,
    output logic                    ram_we,
    output logic [RAM_SIZE_BIT-1:0] ram_addr,
    output logic [31:0]             ram_din,
    input  logic [31:0]             ram_dout,
    output logic [15:0]             stat_stall_cnt,
    output logic [15:0]             stat_dma_cnt
);

    typedef enum logic [0:0] {ST_CPU, ST_DMA_BURST} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DMA} owner_t;

    localparam logic [3:0] MAX_WAIT_W  = 4'(MAX_WAIT);
    localparam logic [7:0] BURST_MAX_W = 8'(BURST_MAX);

    state_t      state, state_d;
    owner_t      rd_owner;
    logic [3:0]  wait_cnt;
    logic [7:0]  beat_cnt;
    logic        idle_q;
    logic        lock_out;
    logic        grant_cpu, grant_dma, burst_exit;
    logic [31:0] cpu_rdata_q, dma_rdata_q;

    // Grant decision and burst control; everything is suppressed while reset is high
    always_comb begin
        state_d    = state;
        grant_cpu  = 1'b0;
        grant_dma  = 1'b0;
        burst_exit = 1'b0;
        if (!reset) begin
            case (state)
                ST_CPU: begin
                    // lock_out keeps the DMA off the RAM for one cycle after a burst
                    if (!lock_out && dma_valid && (!cpu_req || wait_cnt == MAX_WAIT_W))
                        grant_dma = 1'b1;
                    else if (cpu_req)
                        grant_cpu = 1'b1;
                    if (grant_dma && dma_lock) begin
                        if (BURST_MAX > 1)
                            state_d = ST_DMA_BURST;
                        else
                            burst_exit = 1'b1;
                    end
                end
                ST_DMA_BURST: begin
                    grant_dma = dma_valid;
                    if (!dma_lock || (dma_valid && (beat_cnt + 8'd1) >= BURST_MAX_W) ||
                        (!dma_valid && idle_q)) begin
                        state_d    = ST_CPU;
                        burst_exit = 1'b1;
                    end
                end
                default: state_d = ST_CPU;
            endcase
        end
    end

    // RAM port mux, handshakes and read-data return paths
    always_comb begin
        ram_en     = grant_cpu | grant_dma;
        ram_we     = 1'b0;
        ram_addr   = '0;
        ram_din    = '0;
        if (grant_cpu) begin
            ram_we   = cpu_we;
            ram_addr = cpu_addr;
            ram_din  = cpu_wdata;
        end else if (grant_dma) begin
            ram_we   = dma_we;
            ram_addr = dma_addr;
            ram_din  = dma_wdata;
        end
        cpu_stall  = !reset && cpu_req && !grant_cpu;
        dma_ready  = grant_dma;
        cpu_rvalid = !reset && (rd_owner == OWN_CPU);
        dma_rvalid = !reset && (rd_owner == OWN_DMA);
        cpu_rdata  = reset ? 32'h0 : (cpu_rvalid ? ram_dout : cpu_rdata_q);
        dma_rdata  = reset ? 32'h0 : (dma_rvalid ? ram_dout : dma_rdata_q);
    end

    // State, starvation counter, burst beat tracking and read ownership
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_CPU;
            wait_cnt    <= '0;
            beat_cnt    <= '0;
            idle_q      <= 1'b0;
            lock_out    <= 1'b0;
            rd_owner    <= OWN_NONE;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            state    <= state_d;
            lock_out <= burst_exit;
            if (!dma_valid || grant_dma)
                wait_cnt <= '0;
            else if (wait_cnt < MAX_WAIT_W)
                wait_cnt <= wait_cnt + 4'd1;
            if (state_d == ST_CPU)
                beat_cnt <= '0;
            else if (state == ST_CPU)
                beat_cnt <= 8'd1;
            else if (grant_dma)
                beat_cnt <= beat_cnt + 8'd1;
            idle_q <= (state == ST_DMA_BURST) && (state_d == ST_DMA_BURST) && !dma_valid;
            if (grant_cpu && !cpu_we)
                rd_owner <= OWN_CPU;
            else if (grant_dma && !dma_we)
                rd_owner <= OWN_DMA;
            else
                rd_owner <= OWN_NONE;
            cpu_rdata_q <= cpu_rdata;
            dma_rdata_q <= dma_rdata;
        end
    end

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] stall_cnt_q, dma_cnt_q;

    // Saturating event counters for stall cycles and accepted DMA beats
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            dma_cnt_q   <= '0;
        end else begin
            if (cpu_stall && stall_cnt_q != 16'hFFFF)
                stall_cnt_q <= stall_cnt_q + 16'd1;
            if (dma_ready && dma_cnt_q != 16'hFFFF)
                dma_cnt_q <= dma_cnt_q + 16'd1;
        end
    end

    assign stat_stall_cnt = stall_cnt_q;
    assign stat_dma_cnt   = dma_cnt_q;
`else
    assign stat_stall_cnt = 16'h0;
    assign stat_dma_cnt   = 16'h0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed table-driven bench for dmem_arbiter
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [7:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_stall, cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        dma_valid, dma_we, dma_lock;
    logic [7:0]  dma_addr;
    logic [31:0] dma_wdata;
    logic        dma_ready, dma_rvalid;
    logic [31:0] dma_rdata;
    logic        ram_en, ram_we;
    logic [7:0]  ram_addr;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;
    logic [15:0] stat_stall_cnt, stat_dma_cnt;

    int tests = 0;
    int fails = 0;

    dmem_arbiter #(.RAM_SIZE_BIT(8), .MAX_WAIT(4), .BURST_MAX(8)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .dma_valid(dma_valid), .dma_we(dma_we), .dma_lock(dma_lock), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_ready(dma_ready), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
        .stat_stall_cnt(stat_stall_cnt), .stat_dma_cnt(stat_dma_cnt)
    );

    always #5 clk = ~clk;

    // Write-first single-port RAM with one-cycle read latency
    logic [31:0] mem [0:255];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                mem[ram_addr] <= ram_din;
                ram_dout      <= ram_din;
            end else begin
                ram_dout <= mem[ram_addr];
            end
        end
    end

    typedef struct {
        logic        c_req, c_we;
        logic [7:0]  c_addr;
        logic [31:0] c_wdata;
        logic        d_val, d_we, d_lock;
        logic [7:0]  d_addr;
        logic [31:0] d_wdata;
        logic        e_stall, e_rdy, e_en, e_we, e_cv, e_dv;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic c_req, input logic c_we, input logic [7:0] c_addr,
                         input logic [31:0] c_wdata, input logic d_val, input logic d_we,
                         input logic d_lock, input logic [7:0] d_addr, input logic [31:0] d_wdata);
        cpu_req = c_req; cpu_we = c_we; cpu_addr = c_addr; cpu_wdata = c_wdata;
        dma_valid = d_val; dma_we = d_we; dma_lock = d_lock; dma_addr = d_addr; dma_wdata = d_wdata;
    endtask

    task automatic idle();
        drive(0, 0, 8'h0, 32'h0, 0, 0, 0, 8'h0, 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        idle();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int beats;
        //          creq cwe caddr  cwdata        dval dwe dlk daddr  dwdata        stl rdy en we cv dv rdata
        vecs[0]  = '{0, 0, 8'h00, 32'h0,        1, 1, 0, 8'h10, 32'hDEADBEEF, 0, 1, 1, 1, 0, 0, 32'h0};
        vecs[1]  = '{1, 0, 8'h10, 32'h0,        0, 0, 0, 8'h00, 32'h0,        0, 0, 1, 0, 0, 0, 32'h0};
        vecs[2]  = '{0, 0, 8'h00, 32'h0,        1, 1, 0, 8'h20, 32'h12345678, 0, 1, 1, 1, 1, 0, 32'hDEADBEEF};
        vecs[3]  = '{1, 0, 8'h20, 32'h0,        0, 0, 0, 8'h00, 32'h0,        0, 0, 1, 0, 0, 0, 32'h0};
        vecs[4]  = '{0, 0, 8'h00, 32'h0,        0, 0, 0, 8'h00, 32'h0,        0, 0, 0, 0, 1, 0, 32'h12345678};
        vecs[5]  = '{0, 0, 8'h00, 32'h0,        1, 0, 0, 8'h10, 32'h0,        0, 1, 1, 0, 0, 0, 32'h0};
        vecs[6]  = '{1, 1, 8'h30, 32'hAAAA5555, 0, 0, 0, 8'h00, 32'h0,        0, 0, 1, 1, 0, 1, 32'hDEADBEEF};
        vecs[7]  = '{1, 0, 8'h30, 32'h0,        1, 0, 0, 8'h20, 32'h0,        0, 0, 1, 0, 0, 0, 32'h0};
        vecs[8]  = '{0, 0, 8'h00, 32'h0,        0, 0, 0, 8'h00, 32'h0,        0, 0, 0, 0, 1, 0, 32'hAAAA5555};
        vecs[9]  = '{1, 1, 8'h31, 32'h0BADF00D, 1, 0, 0, 8'h10, 32'h0,        0, 0, 1, 1, 0, 0, 32'h0};
        vecs[10] = '{0, 0, 8'h00, 32'h0,        0, 0, 0, 8'h00, 32'h0,        0, 0, 0, 0, 0, 0, 32'h0};

        reset = 1'b1;
        idle();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_stall", {31'b0, cpu_stall}, 0);
        chk("rst_ready", {31'b0, dma_ready}, 0);
        chk("rst_ram_en", {31'b0, ram_en}, 0);
        chk("rst_cpu_rvalid", {31'b0, cpu_rvalid}, 0);
        chk("rst_dma_rvalid", {31'b0, dma_rvalid}, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_dma_rdata", dma_rdata, 0);
        chk("rst_stat_stall", {16'b0, stat_stall_cnt}, 0);

        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            drive(vecs[i].c_req, vecs[i].c_we, vecs[i].c_addr, vecs[i].c_wdata, vecs[i].d_val,
                  vecs[i].d_we, vecs[i].d_lock, vecs[i].d_addr, vecs[i].d_wdata);
            #1;
            chk($sformatf("v%0d_stall", i), {31'b0, cpu_stall}, {31'b0, vecs[i].e_stall});
            chk($sformatf("v%0d_ready", i), {31'b0, dma_ready}, {31'b0, vecs[i].e_rdy});
            chk($sformatf("v%0d_ram_en", i), {31'b0, ram_en}, {31'b0, vecs[i].e_en});
            chk($sformatf("v%0d_ram_we", i), {31'b0, ram_we}, {31'b0, vecs[i].e_we});
            chk($sformatf("v%0d_cpu_rvalid", i), {31'b0, cpu_rvalid}, {31'b0, vecs[i].e_cv});
            chk($sformatf("v%0d_dma_rvalid", i), {31'b0, dma_rvalid}, {31'b0, vecs[i].e_dv});
            if (vecs[i].e_cv) chk($sformatf("v%0d_cpu_rdata", i), cpu_rdata, vecs[i].e_rdata);
            if (vecs[i].e_dv) chk($sformatf("v%0d_dma_rdata", i), dma_rdata, vecs[i].e_rdata);
        end

        // Starvation: DMA forced in every fifth cycle while the CPU requests continuously
        do_reset();
        for (int c = 0; c < 20; c++) begin
            if (c != 0) @(negedge clk);
            drive(1, 0, 8'h10, 32'h0, 1, 0, 0, 8'h20, 32'h0);
            #1;
            chk($sformatf("starve_c%0d_stall", c), {31'b0, cpu_stall}, {31'b0, (c % 5) == 4});
            chk($sformatf("starve_c%0d_ready", c), {31'b0, dma_ready}, {31'b0, (c % 5) == 4});
        end
        @(negedge clk);
        idle();
        #1;
`ifdef DMEM_ARB_STATS_EN
        chk("stat_stall_cnt", {16'b0, stat_stall_cnt}, 4);
        chk("stat_dma_cnt", {16'b0, stat_dma_cnt}, 4);
`else
        chk("stat_stall_cnt", {16'b0, stat_stall_cnt}, 0);
        chk("stat_dma_cnt", {16'b0, stat_dma_cnt}, 0);
`endif

        // Locked write burst capped at BURST_MAX, then a one-cycle lock-out
        do_reset();
        beats = 0;
        for (int c = 0; c < 13; c++) begin
            if (c != 0) @(negedge clk);
            drive(1, 0, 8'h40, 32'h0, 1, 1, 1, 8'h50 + 8'(c), 32'hB000_0000 + 32'(c));
            #1;
            if (dma_ready) beats++;
            chk($sformatf("burst_c%0d_stall", c), {31'b0, cpu_stall}, {31'b0, c >= 4 && c <= 11});
            chk($sformatf("burst_c%0d_ready", c), {31'b0, dma_ready}, {31'b0, c >= 4 && c <= 11});
        end
        chk("burst_beats", 32'(beats), 8);
        chk("lockout_cpu_en", {31'b0, ram_en}, 1);

        // Re-lock after the lock-out cycle, as a read burst
        @(negedge clk);
        drive(0, 0, 8'h0, 32'h0, 1, 0, 1, 8'h55, 32'h0);
        #1;
        chk("relock_ready", {31'b0, dma_ready}, 1);
        @(negedge clk);
        drive(1, 0, 8'h40, 32'h0, 1, 0, 1, 8'h56, 32'h0);
        #1;
        chk("rburst_stall", {31'b0, cpu_stall}, 1);
        chk("rburst_dma_rvalid", {31'b0, dma_rvalid}, 1);
        chk("rburst_dma_rdata", dma_rdata, 32'hB000_0005);

        // Reset at beat 3 of the read burst
        @(negedge clk);
        reset = 1'b1;
        drive(1, 0, 8'h40, 32'h0, 1, 0, 1, 8'h57, 32'h0);
        #1;
        chk("rst_mid_dma_rvalid", {31'b0, dma_rvalid}, 0);
        chk("rst_mid_ram_en", {31'b0, ram_en}, 0);
        @(negedge clk);
        reset = 1'b0;
        drive(1, 0, 8'h40, 32'h0, 1, 0, 1, 8'h58, 32'h0);
        #1;
        chk("post_rst_dma_rvalid", {31'b0, dma_rvalid}, 0);
        chk("post_rst_dma_rdata", dma_rdata, 0);
        chk("post_rst_cpu_rvalid", {31'b0, cpu_rvalid}, 0);
        chk("post_rst_stall", {31'b0, cpu_stall}, 0);
        chk("post_rst_ready", {31'b0, dma_ready}, 0);
        chk("post_rst_cpu_grant", {31'b0, ram_en}, 1);

        @(negedge clk);
        idle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
